// File: rtl/tile_pkg.sv
// Shared constants and enums for the world-map tile probe path.
// Geometry matches the 640x480 screen built from 16-pixel tiles, 40 columns wide.
package tile_pkg;
  localparam int TILE_PX          = 16;
  localparam int MAP_COLS         = 40;
  localparam int TILES_PER_SCREEN = 1200;
  localparam int SCREEN_W         = 640;
  localparam int SCREEN_H         = 480;

  localparam logic [4:0] OOB_TILE_DEF = 5'd0;

  typedef enum logic [1:0] {DIR_R, DIR_L, DIR_U, DIR_D} probe_dir_t;

  typedef enum logic [2:0] {IDLE, CAPTURE, ISSUE, WAIT, DONE} probe_state_t;
endpackage

// File: rtl/tile_probe_sequencer_if.sv
// Bundle between the probe sequencer, world_rom2, the renderer address path and player physics.
// The slave modport is the sequencer; the master modport is everything around it.
interface tile_probe_sequencer_if;
  logic        Frame_Start;
  logic [9:0]  X_Pos;
  logic [9:0]  Y_Pos;
  logic [7:0]  Scroll_Col;
  logic        Render_Req;
  logic [12:0] Render_Addr;
  logic [12:0] Rom_Addr;
  logic [4:0]  Rom_Data;
  logic        Render_Grant;
  logic [4:0]  Index_R, Index_L, Index_U, Index_D;
  logic        Solid_R, Solid_L, Solid_U, Solid_D;
  logic        Probe_Valid;
  logic        Probe_Done;
  logic        Busy;

  modport master (
    output Frame_Start, X_Pos, Y_Pos, Scroll_Col, Render_Req, Render_Addr, Rom_Data,
    input  Rom_Addr, Render_Grant, Index_R, Index_L, Index_U, Index_D,
    input  Solid_R, Solid_L, Solid_U, Solid_D, Probe_Valid, Probe_Done, Busy
  );

  modport slave (
    input  Frame_Start, X_Pos, Y_Pos, Scroll_Col, Render_Req, Render_Addr, Rom_Data,
    output Rom_Addr, Render_Grant, Index_R, Index_L, Index_U, Index_D,
    output Solid_R, Solid_L, Solid_U, Solid_D, Probe_Valid, Probe_Done, Busy
  );
endinterface

// File: rtl/tile_addr_calc.sv
// Pixel point plus scroll -> world_rom2 tile address and out-of-map flag.
// Purely combinational; shared with the renderer.
module tile_addr_calc
  import tile_pkg::*;
#(
  parameter int NUM_SCREENS = 6
) (
  input  logic signed [10:0] px,
  input  logic signed [10:0] py,
  input  logic [7:0]         scroll_col,
  output logic [12:0]        addr,
  output logic               oob
);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);
  localparam logic [3:0]         NS    = 4'(NUM_SCREENS);

  logic [8:0] col;
  logic [2:0] screen;
  logic [5:0] col_in;

  always_comb begin
    col    = {3'b000, px[9:4]} + {1'b0, scroll_col};
    screen = 3'(col / 9'd40);
    col_in = 6'(col % 9'd40);
    // 13-bit arithmetic wraps exactly like the truncated ROM address bus
    addr   = 13'(col_in) + 13'(py[9:4]) * 13'(MAP_COLS) + 13'(screen) * 13'(TILES_PER_SCREEN);
    oob    = px[10] || (px > X_MAX) || py[10] || (py > Y_MAX) || ({1'b0, screen} >= NS);
  end
endmodule

// File: rtl/tile_probe_sequencer.sv
// Once per frame reads the tiles right/left/up/down of the sprite through the shared ROM port.
// Renderer always wins the port; each probe costs 1+ROM_LAT cycles, OOB probes 1, stalls add 1 each.
module tile_probe_sequencer
  import tile_pkg::*;
#(
  parameter int         ROM_LAT     = 1,
  parameter int         NUM_SCREENS = 6,
  parameter logic [4:0] OOB_TILE    = OOB_TILE_DEF
) (
  input logic                   Clk,
  input logic                   Reset_n,
  tile_probe_sequencer_if.slave bus
);
  probe_state_t      state, state_nxt;
  probe_dir_t        dir, dir_nxt;
  logic [9:0]        x_q, y_q;
  logic [7:0]        scroll_q;
  logic [1:0]        cnt, cnt_nxt;
  logic              valid, valid_nxt;
  logic              cap, store;
  logic [4:0]        store_dat;
  logic [4:0]        idx_q [4];
  logic signed [10:0] xs, ys, px, py;
  logic [12:0]       probe_addr;
  logic              probe_oob;

  assign xs = signed'({1'b0, x_q});
  assign ys = signed'({1'b0, y_q});

  always_comb begin
    px = xs;
    py = ys;
    case (dir)
      DIR_R:   px = xs + 11'sd18;
      DIR_L:   px = xs - 11'sd2;
      DIR_U:   py = ys - 11'sd2;
      default: py = ys + 11'sd18;
    endcase
  end

  tile_addr_calc #(.NUM_SCREENS(NUM_SCREENS)) u_addr (
    .px         (px),
    .py         (py),
    .scroll_col (scroll_q),
    .addr       (probe_addr),
    .oob        (probe_oob)
  );

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    valid_nxt = valid;
    cap       = 1'b0;
    store     = 1'b0;
    store_dat = OOB_TILE;
    case (state)
      IDLE: if (bus.Frame_Start) state_nxt = CAPTURE;
      CAPTURE: begin
        cap       = 1'b1;
        dir_nxt   = DIR_R;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (probe_oob) begin
          store = 1'b1;
        end else if (!bus.Render_Req) begin
          cnt_nxt   = 2'(ROM_LAT);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd1) begin
          store     = 1'b1;
          store_dat = bus.Rom_Data;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (store) begin
      if (dir == DIR_D) begin
        state_nxt = DONE;
        valid_nxt = 1'b1;
      end else begin
        dir_nxt   = probe_dir_t'(dir + 2'd1);
        state_nxt = ISSUE;
      end
    end
    // A new frame pulse aborts whatever is in flight, including the pending store
    if (bus.Frame_Start && state != IDLE) begin
      store     = 1'b0;
      state_nxt = CAPTURE;
    end
    if (state_nxt == CAPTURE) valid_nxt = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      dir      <= DIR_R;
      cnt      <= '0;
      valid    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      scroll_q <= '0;
      for (int i = 0; i < 4; i++) idx_q[i] <= OOB_TILE;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      cnt   <= cnt_nxt;
      valid <= valid_nxt;
      if (cap) begin
        x_q      <= bus.X_Pos;
        y_q      <= bus.Y_Pos;
        scroll_q <= bus.Scroll_Col;
      end
      if (store) idx_q[dir] <= store_dat;
    end
  end

  assign bus.Rom_Addr     = (state == ISSUE && !bus.Render_Req && !probe_oob) ? probe_addr : bus.Render_Addr;
  assign bus.Render_Grant = bus.Render_Req;
  assign bus.Index_R      = idx_q[DIR_R];
  assign bus.Index_L      = idx_q[DIR_L];
  assign bus.Index_U      = idx_q[DIR_U];
  assign bus.Index_D      = idx_q[DIR_D];
  assign bus.Solid_R      = ~idx_q[DIR_R][0];
  assign bus.Solid_L      = ~idx_q[DIR_L][0];
  assign bus.Solid_U      = ~idx_q[DIR_U][0];
  assign bus.Solid_D      = ~idx_q[DIR_D][0];
  assign bus.Probe_Valid  = valid;
  assign bus.Probe_Done   = (state == DONE);
  assign bus.Busy         = (state != IDLE);
endmodule

// File: tb/tb_tile_probe_sequencer.sv
// Directed bench for tile_probe_sequencer with a 1-cycle ROM model (data = addr[4:0] ^ 5'h15).
module tb_tile_probe_sequencer;
  import tile_pkg::*;

  localparam logic [12:0] SENTINEL = 13'h1FFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_probe_sequencer_if bus ();

  tile_probe_sequencer #(.ROM_LAT(1), .NUM_SCREENS(6), .OOB_TILE(5'd0)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  function automatic logic [4:0] rom_fn(input logic [12:0] a);
    return a[4:0] ^ 5'h15;
  endfunction

  always @(posedge clk) bus.Rom_Data <= rom_fn(bus.Rom_Addr);

  int    n_chk  = 0;
  int    n_pass = 0;
  int    lat, ndone, early, stall_chg, ren_bad;
  int    issue_log[$];
  string dn[4] = '{"R", "L", "U", "D"};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [19:0] cur_idx();
    return {bus.Index_R, bus.Index_L, bus.Index_U, bus.Index_D};
  endfunction

  task automatic check_idx(input string t, input logic [4:0] ei[4]);
    logic [4:0] gi[4];
    logic       gs[4];
    gi = '{bus.Index_R, bus.Index_L, bus.Index_U, bus.Index_D};
    gs = '{bus.Solid_R, bus.Solid_L, bus.Solid_U, bus.Solid_D};
    for (int i = 0; i < 4; i++) begin
      chk({t, ".idx_", dn[i]}, int'(gi[i]), int'(ei[i]));
      chk({t, ".solid_", dn[i]}, int'(gs[i]), ei[i][0] ? 0 : 1);
    end
  endtask

  // st0/stn: renderer stall start cycle and length; rs: cycle of a second Frame_Start (-1 = none)
  task automatic run_frame(input int x, input int y, input int s, input int st0, input int stn, input int rs);
    logic [19:0] snap;
    snap = '0;
    lat = -1; ndone = 0; early = 0; stall_chg = 0; ren_bad = 0;
    issue_log.delete();
    @(negedge clk);
    bus.X_Pos       = 10'(x);
    bus.Y_Pos       = 10'(y);
    bus.Scroll_Col  = 8'(s);
    bus.Frame_Start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0 || cyc == rs + 1) bus.Frame_Start = 1'b0;
      if (cyc == rs) bus.Frame_Start = 1'b1;
      if (cyc == st0) begin bus.Render_Req = 1'b1; bus.Render_Addr = 13'd100; end
      if (cyc == st0 + stn) begin bus.Render_Req = 1'b0; bus.Render_Addr = SENTINEL; end
      #1;
      if (cyc == st0) snap = cur_idx();
      if (bus.Render_Grant != bus.Render_Req) ren_bad++;
      if (bus.Render_Req) begin
        if (bus.Rom_Addr != bus.Render_Addr) ren_bad++;
        if (cur_idx() != snap) stall_chg++;
      end else if (bus.Rom_Addr != bus.Render_Addr) begin
        issue_log.push_back(int'(bus.Rom_Addr));
      end
      if (bus.Probe_Done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end else if (lat < 0 && bus.Probe_Valid) begin
        early++;
      end
    end
  endtask

  // el holds the expected final (up to 4) issued addresses
  task automatic check_frame(input string t, input int exp_lat, input int nlog, input int el[4],
                             input logic [4:0] ei[4]);
    int ncheck, k;
    chk({t, ".lat"}, lat, exp_lat);
    chk({t, ".ndone"}, ndone, 1);
    chk({t, ".early_valid"}, early, 0);
    chk({t, ".valid"}, int'(bus.Probe_Valid), 1);
    chk({t, ".busy"}, int'(bus.Busy), 0);
    chk({t, ".ren"}, ren_bad, 0);
    chk({t, ".nissue"}, issue_log.size(), nlog);
    ncheck = (nlog > 4) ? 4 : nlog;
    for (int i = 0; i < ncheck; i++) begin
      k = issue_log.size() - ncheck + i;
      chk({t, $sformatf(".addr%0d", i)}, (k >= 0) ? issue_log[k] : -1, el[i]);
    end
    check_idx(t, ei);
  endtask

  initial begin
    int dcount;
    bus.Frame_Start = 1'b0;
    bus.X_Pos       = '0;
    bus.Y_Pos       = '0;
    bus.Scroll_Col  = '0;
    bus.Render_Req  = 1'b0;
    bus.Render_Addr = SENTINEL;

    repeat (2) @(negedge clk);
    #1;
    check_idx("rst", '{5'd0, 5'd0, 5'd0, 5'd0});
    chk("rst.valid", int'(bus.Probe_Valid), 0);
    chk("rst.done", int'(bus.Probe_Done), 0);
    chk("rst.busy", int'(bus.Busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(288, 160, 30, -1, 0, -1);
    check_frame("base", 9, 4, '{1609, 1607, 1568, 1648}, '{5'd28, 5'd18, 5'd21, 5'd5});

    run_frame(1, 0, 0, -1, 0, -1);
    check_frame("edge", 7, 2, '{1, 40, 0, 0}, '{5'd20, 5'd0, 5'd0, 5'd29});

    run_frame(288, 160, 30, 1, 20, -1);
    check_frame("stall", 29, 4, '{1609, 1607, 1568, 1648}, '{5'd28, 5'd18, 5'd21, 5'd5});
    chk("stall.idx_chg", stall_chg, 0);

    run_frame(288, 160, 240, -1, 0, -1);
    check_frame("scroll", 5, 0, '{0, 0, 0, 0}, '{5'd0, 5'd0, 5'd0, 5'd0});

    run_frame(288, 160, 30, -1, 0, 6);
    check_frame("restart", 16, 7, '{1609, 1607, 1568, 1648}, '{5'd28, 5'd18, 5'd21, 5'd5});

    // Asynchronous reset landing mid-WAIT
    @(negedge clk);
    bus.Frame_Start = 1'b1;
    @(negedge clk);
    bus.Frame_Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst.busy_pre", int'(bus.Busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idx("arst", '{5'd0, 5'd0, 5'd0, 5'd0});
    chk("arst.valid", int'(bus.Probe_Valid), 0);
    chk("arst.done", int'(bus.Probe_Done), 0);
    chk("arst.busy", int'(bus.Busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Probe_Done) dcount++;
    end
    chk("arst.no_done", dcount, 0);
    chk("arst.idle", int'(bus.Busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
